// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB completer with a 32-bit register bank, read-only ID at
//               index 0, programmable wait states and Pslverr on bad access.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int          NREGS       = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int         IW = $clog2(NREGS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [3:0]  cnt_q;
    logic [31:0] prdata_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] regs_q [NREGS];

    logic        setup_d;
    logic [31:0] dec_addr_d;
    logic        dec_write_d;
    logic [5:0]  idx_d;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        complete_d;
    logic        commit_d;

    assign setup_d = (state_q == S_IDLE) && Psel && !Penable;

    // With zero wait states the response is formed on the setup edge itself,
    // so decode looks at the live bus then and at the latched request after.
    assign dec_addr_d  = setup_d ? Paddr  : addr_q;
    assign dec_write_d = setup_d ? Pwrite : write_q;
    assign idx_d       = dec_addr_d[7:2];

    always_comb begin
        err_d = (dec_addr_d[31:8] != BASE_ADDR[31:8])
             || (dec_addr_d[1:0] != 2'b00)
             || (32'(idx_d) >= 32'(NREGS))
             || (dec_write_d && (idx_d == 6'd0));
        rdata_d = 32'h0;
        if (!err_d && !dec_write_d) begin
            if (idx_d == 6'd0) begin
                rdata_d = ID_VALUE;
            end else begin
                rdata_d = regs_q[idx_d[IW-1:0]];
            end
        end
    end

    assign complete_d = (state_q == S_ACCESS) && Psel && Penable && pready_q;
    assign commit_d   = complete_d && write_q && !pslverr_q;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            write_q   <= 1'b0;
            cnt_q     <= 4'd0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (setup_d) begin
                        state_q <= S_ACCESS;
                        addr_q  <= Paddr;
                        write_q <= Pwrite;
                        wdata_q <= Pwdata;
                        cnt_q   <= WS;
                        if (WS == 4'd0) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_d;
                            pslverr_q <= err_d;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!Psel || complete_d) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= 4'd0;
                        prdata_q  <= 32'h0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else if (!pready_q) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_d;
                            pslverr_q <= err_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (commit_d) begin
            regs_q[addr_q[2 +: IW]] <= wdata_q;
        end
    end

    assign Prdata  = prdata_q;
    assign Pready  = pready_q;
    assign Pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regfile
// Description : Directed bench for two apb_slave_regfile instances
//               (0 and 3 wait states) sharing one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

    logic        clk;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic        er;
    int          wt;

    apb_slave_regfile #(.NREGS(8), .WAIT_STATES(0)) dut_a (
        .Hclk(clk), .Hreset(rst),
        .Psel(psel[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
        .Paddr(paddr[0]), .Pwdata(pwdata[0]),
        .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
    );

    apb_slave_regfile #(.NREGS(8), .WAIT_STATES(3)) dut_b (
        .Hclk(clk), .Hreset(rst),
        .Psel(psel[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
        .Paddr(paddr[1]), .Pwdata(pwdata[1]),
        .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completion edge
    // so a following call issues its setup back-to-back.
    task automatic apb(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdo,
                       output logic ero, output int waits);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(negedge clk);
        chk("pready_low_in_setup", {31'h0, pready[d]}, 32'h0);
        @(posedge clk);
        #1;
        penable[d] = 1'b1;
        waits = 0;
        rdo   = 32'h0;
        ero   = 1'b0;
        forever begin
            @(negedge clk);
            if (pready[d] === 1'b1) begin
                rdo = prdata[d];
                ero = pslverr[d];
                break;
            end
            waits++;
            if (waits > 40) begin
                chk("pready_timeout", 32'(waits), 32'h0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 32'h0; pwdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pready_a",  {31'h0, pready[0]},  32'h0);
        chk("rst_pslverr_a", {31'h0, pslverr[0]}, 32'h0);
        chk("rst_prdata_a",  prdata[0],           32'h0);
        chk("rst_pready_b",  {31'h0, pready[1]},  32'h0);
        @(posedge clk);
        #1;

        // Zero-wait ID read, write then back-to-back readback
        apb(0, 1'b0, 32'h8000_0000, 32'h0, rd, er, wt);
        chk("id_rdata", rd, 32'hA2B0_0001);
        chk("id_err",   {31'h0, er}, 32'h0);
        chk("id_waits", 32'(wt), 32'd0);
        apb(0, 1'b1, 32'h8000_0008, 32'h8765_4321, rd, er, wt);
        chk("wr2_err",   {31'h0, er}, 32'h0);
        chk("wr2_waits", 32'(wt), 32'd0);
        apb(0, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
        chk("rd2_rdata", rd, 32'h8765_4321);
        chk("rd2_waits", 32'(wt), 32'd0);

        // Three wait states
        apb(1, 1'b1, 32'h8000_0004, 32'hABCD_EF01, rd, er, wt);
        chk("b_wr1_waits", 32'(wt), 32'd3);
        chk("b_wr1_err",   {31'h0, er}, 32'h0);
        apb(1, 1'b0, 32'h8000_0004, 32'h0, rd, er, wt);
        chk("b_rd1_rdata", rd, 32'hABCD_EF01);
        chk("b_rd1_waits", 32'(wt), 32'd3);

        // Error responses
        apb(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rd, er, wt);
        chk("wr_reg0_err", {31'h0, er}, 32'h1);
        apb(0, 1'b0, 32'h8000_0000, 32'h0, rd, er, wt);
        chk("id_after_wr_reg0", rd, 32'hA2B0_0001);
        apb(0, 1'b0, 32'h8000_0020, 32'h0, rd, er, wt);
        chk("rd_oob_err",   {31'h0, er}, 32'h1);
        chk("rd_oob_rdata", rd, 32'h0);
        apb(0, 1'b1, 32'h8000_0006, 32'h0000_0001, rd, er, wt);
        chk("wr_misalign_err", {31'h0, er}, 32'h1);
        apb(0, 1'b0, 32'h8000_0004, 32'h0, rd, er, wt);
        chk("reg1_untouched", rd, 32'h0);
        apb(0, 1'b0, 32'h8000_0006, 32'h0, rd, er, wt);
        chk("rd_misalign_err",   {31'h0, er}, 32'h1);
        chk("rd_misalign_rdata", rd, 32'h0);
        apb(0, 1'b1, 32'h9000_0008, 32'h0000_1234, rd, er, wt);
        chk("wr_window_err", {31'h0, er}, 32'h1);
        apb(0, 1'b1, 32'hDDDD_DDDD, 32'h0000_0005, rd, er, wt);
        chk("wr_dddd_err", {31'h0, er}, 32'h1);
        apb(0, 1'b0, 32'hDDDD_DDDD, 32'h0, rd, er, wt);
        chk("rd_dddd_err",   {31'h0, er}, 32'h1);
        chk("rd_dddd_rdata", rd, 32'h0);
        apb(0, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
        chk("reg2_untouched", rd, 32'h8765_4321);

        // Abort: Psel dropped mid-ACCESS on the wait-state slave
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8000_0008; pwdata[1] = 32'h1111_1111;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pready", {31'h0, pready[1]}, 32'h0);
        @(posedge clk); #1;
        apb(1, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
        chk("abort_no_write", rd, 32'h0);
        chk("abort_next_waits", 32'(wt), 32'd3);

        // Reset in the middle of a write's ACCESS phase
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8000_0010; pwdata[1] = 32'h2222_2222;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        chk("midrst_pready_b", {31'h0, pready[1]}, 32'h0);
        chk("midrst_pready_a", {31'h0, pready[0]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        apb(1, 1'b0, 32'h8000_0010, 32'h0, rd, er, wt);
        chk("midrst_reg4", rd, 32'h0);
        chk("midrst_reg4_waits", 32'(wt), 32'd3);
        apb(1, 1'b0, 32'h8000_0004, 32'h0, rd, er, wt);
        chk("rst_clears_b_reg1", rd, 32'h0);
        apb(1, 1'b1, 32'h8000_0008, 32'h0000_0033, rd, er, wt);
        chk("post_rst_wr_err", {31'h0, er}, 32'h0);
        apb(1, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
        chk("post_rst_rd", rd, 32'h0000_0033);
        apb(0, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
        chk("rst_clears_a_reg2", rd, 32'h0);
        @(negedge clk);
        chk("pready_one_cycle", {31'h0, pready[0]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
